// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit start validation,
// bit-centre sampling and a valid/ready byte handoff with framing and overrun flags.
module uart_rx #(
    parameter int BAUDRATE = 125000000 / 115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int H  = BAUDRATE / 2;
    localparam int CW = $clog2(BAUDRATE);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUDRATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_m;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [2:0]      idx;
    logic [2:0]      idx_nxt;
    logic [7:0]      shift;
    logic [7:0]      shift_nxt;
    logic            stop_hit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shift <= shift_nxt;
        end
    end

    // The counter only runs while timing a bit; IDLE and BREAK keep it parked at 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        shift_nxt = shift;
        stop_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_DATA;
                        idx_nxt   = '0;
                    end
                end
            end
            S_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift[7:1]};
                    if (idx == 3'd7) state_nxt = S_STOP;
                    else             idx_nxt   = idx + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt   = '0;
                    stop_hit  = 1'b1;
                    state_nxt = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A new byte always wins; overrun records that the held one was never taken.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (stop_hit) begin
            data_out  <= shift;
            frame_err <= ~rx_s;
            valid     <= 1'b1;
            overrun   <= valid && !ready;
        end else if (valid && ready) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: reset, nominal byte, glitch,
// break, overrun, accept-on-stop-edge and mid-frame reset.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx #(.BAUDRATE(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .ready     (ready),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start bit plus eight data bits, LSB first; leaves the caller just after edge 143.
    task automatic send_data(input logic [7:0] b);
        rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_data(b);
        rx = stop;
        repeat (16) tick();
    endtask

    initial begin
        int bcount;
        int vseen;

        rstn  = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (3) tick();
        check("rst_data", data_out, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rstn = 1'b1;
        repeat (5) tick();

        // 1: nominal byte, exact valid timing, registered fall on accept
        send_data(8'hA5);
        rx = 1'b1;
        repeat (10) tick();
        check("t1_valid_e153", valid, 1'b0);
        tick();
        check("t1_valid_e154", valid, 1'b1);
        check("t1_data", data_out, 8'hA5);
        check("t1_ferr", frame_err, 1'b0);
        check("t1_ovr", overrun, 1'b0);
        repeat (5) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t1_accept", valid, 1'b0);
        repeat (10) tick();

        // 2: 4-clock glitch on the idle line
        bcount = 0;
        vseen  = 0;
        rx = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) rx = 1'b1;
            tick();
            if (busy)  bcount++;
            if (valid) vseen++;
        end
        check("t2_busy_cycles", bcount, 8);
        check("t2_no_valid", vseen, 0);
        check("t2_busy_end", busy, 1'b0);

        // 3: framing error followed by a held break
        send_data(8'h3C);
        rx = 1'b0;
        repeat (56) tick();
        check("t3_valid", valid, 1'b1);
        check("t3_data", data_out, 8'h3C);
        check("t3_ferr", frame_err, 1'b1);
        check("t3_busy_break", busy, 1'b1);
        rx = 1'b1;
        tick();
        tick();
        check("t3_busy_e1", busy, 1'b1);
        tick();
        check("t3_busy_e2", busy, 1'b0);
        repeat (30) tick();
        check("t3_no_second", data_out, 8'h3C);
        check("t3_ovr", overrun, 1'b0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t3_accept", valid, 1'b0);
        repeat (5) tick();

        // 4: back-to-back frames with the first never accepted
        send_frame(8'h3C, 1'b1);
        check("t4_first_data", data_out, 8'h3C);
        check("t4_first_ovr", overrun, 1'b0);
        send_frame(8'hC3, 1'b1);
        check("t4_second_data", data_out, 8'hC3);
        check("t4_second_ovr", overrun, 1'b1);
        check("t4_second_ferr", frame_err, 1'b0);
        check("t4_second_valid", valid, 1'b1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t4_accept_valid", valid, 1'b0);
        check("t4_accept_ovr", overrun, 1'b0);
        repeat (5) tick();

        // 5: consumer accepts exactly on the second byte's stop sample edge
        send_frame(8'h3C, 1'b1);
        check("t5_first_valid", valid, 1'b1);
        send_data(8'hC3);
        rx = 1'b1;
        repeat (10) tick();
        check("t5_held_data", data_out, 8'h3C);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t5_data", data_out, 8'hC3);
        check("t5_valid", valid, 1'b1);
        check("t5_ovr", overrun, 1'b0);
        repeat (5) tick();

        // 6: reset during data bit 4, then a clean frame
        repeat (10) tick();
        rx = 1'b0;
        repeat (16 + 64 + 8) tick();
        check("t6_busy_mid", busy, 1'b1);
        rstn = 1'b0;
        rx   = 1'b1;
        tick();
        rstn = 1'b1;
        check("t6_rst_data", data_out, 8'h00);
        check("t6_rst_valid", valid, 1'b0);
        check("t6_rst_ferr", frame_err, 1'b0);
        check("t6_rst_ovr", overrun, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        repeat (20) tick();
        check("t6_idle_valid", valid, 1'b0);
        send_frame(8'h5A, 1'b1);
        check("t6_valid", valid, 1'b1);
        check("t6_data", data_out, 8'h5A);
        check("t6_ferr", frame_err, 1'b0);
        check("t6_ovr", overrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, 8N1, LSB first, idle-high line, with built-in bit timing derived from the same `BAUDRATE` divisor used by the transmit-side baud generator. Sits between the asynchronous `rx` pin and the byte-oriented consumer logic. It synchronises the line, validates the start bit at mid-bit, samples data and stop bits at bit centres, and hands each byte over on a valid/ready handshake with framing-error and overrun status.

## Interface
- `BAUDRATE`, default `125000000/115200` (=1085): system clocks per bit. Legal values are ≥ 4. `H = BAUDRATE/2` (integer division).
- `clk` input 1: system clock.
- `rstn` input 1: reset, synchronous, active-low.
- `rx` input 1: asynchronous serial line, idle high.
- `data_out` output 8: received byte.
- `valid` output 1: `data_out`, `frame_err` and `overrun` are meaningful.
- `ready` input 1: consumer accepts the byte on a cycle where `valid && ready`.
- `frame_err` output 1: stop bit of the held byte sampled 0.
- `overrun` output 1: an unaccepted byte was overwritten by the held byte.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- Synchroniser: two flops on `rx` produce `rx_s`. Both flops reset to 1.
- Bit counter: `cnt`, `$clog2(BAUDRATE)` bits. It is cleared on every state entry and at every sample point, and otherwise increments by 1. It never wraps on its own.
- Bit index: `idx`, 3 bits. Shift register: 8 bits, filled LSB first. The received bit enters at bit 7 and the register shifts right.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rx_s==0`, go to START with `cnt=0`.
  - START: sample at `cnt==H-1`.
    - `rx_s==1`: glitch. Return to IDLE. No output change.
    - `rx_s==0`: go to DATA with `idx=0` and `cnt=0`.
  - DATA: sample at `cnt==BAUDRATE-1` and shift in `rx_s`. When `idx==7`, go to STOP. Otherwise increment `idx`.
  - STOP: sample at `cnt==BAUDRATE-1`. On that edge:
    - Load `data_out` from the shift register.
    - Set `frame_err` to the inverse of the stop bit.
    - Set `valid=1`.
    - Next state is IDLE if the stop bit is 1, or BREAK if it is 0.
  - BREAK: stay until `rx_s==1`, then go to IDLE. No new start bit is detected while in BREAK.
- Output update rules, applied on the STOP sample edge:
  - `valid==0`, or `valid && ready` on the same edge: load the new byte and set `overrun=0`.
  - `valid==1` and `ready==0`: load the new byte and set `overrun=1`.
  - On any other edge with `valid && ready`: set `valid=0` and `overrun=0`. `data_out` and `frame_err` hold their values.
- Reset (`rstn==0` at an edge), including mid-frame:
  - FSM goes to IDLE; `cnt`, `idx` and the shift register clear.
  - `data_out=0`, `valid=0`, `frame_err=0`, `overrun=0`, `busy=0`.
  - Synchroniser flops go to 1.
  - A partial frame is discarded. Reception resumes with the next start bit after `rstn` returns high.

## Timing
- Let edge 0 be the first clock edge at which `rx` is sampled low.
  - `rx_s` is low after edge 1.
  - START is entered at edge 2.
  - The start bit is sampled at edge 2+H.
  - Data bit i is sampled at edge 2+H+(i+1)·BAUDRATE.
  - The stop bit is sampled at edge 2+H+9·BAUDRATE. `valid` is high after that edge.
- With `BAUDRATE=16`, `valid` is high after edge 154.
- `busy` is high from edge 2 until the edge that enters IDLE.
- Back-to-back frames: a start bit that follows the stop bit immediately is detected. IDLE is entered H cycles before the nominal end of the stop bit.
- `valid` stays high until it is accepted. Its fall is registered: it is low on the cycle after the accepting edge.

## Test plan
All scenarios use `BAUDRATE=16`, with the bench driving `rx` at 16 clocks per bit.
1. Send 0xA5 with a good stop bit and `ready=0`. `valid` rises after edge 154 with `data_out=0xA5`, `frame_err=0`, `overrun=0`. Pulse `ready` for one cycle: `valid=0` on the next cycle.
2. Drive a low pulse of 4 clocks on idle `rx`. `busy` is high for 8 cycles, then returns to 0. `valid` never rises.
3. Send 0x3C with stop bit 0 and hold `rx` low for 40 more clocks. `valid=1`, `data_out=0x3C`, `frame_err=1`. `busy` stays 1 until 2 clocks after `rx` returns high. No spurious second byte appears.
4. Send 0x3C then 0xC3 back-to-back with `ready=0`. After the second stop bit: `data_out=0xC3`, `overrun=1`. Assert `ready`: `valid=0` and `overrun=0`.
5. Assert `ready` exactly on the STOP sample edge of the second byte while the first is held. `data_out=0xC3`, `valid` stays 1, `overrun=0`.
6. Assert `rstn=0` for one cycle during data bit 4 of a frame. All outputs are 0 and `busy=0`. The next frame, 0x5A, is received correctly with `frame_err=0`.
